encoder83_queue: RTL and testbench

Sequential 8-to-3 encoder: the inverse of the 3-to-8 decoder. It captures an 8-bit multi-hot request word and emits, one per handshake, the 3-bit index of every set bit in fixed priority order. The `out_last` flag marks the final index. It sits between request-generating logic and any consumer that speaks in 3-bit codes, such as a downstream 3-to-8 decoder, and turns a bitmap back into a code stream.

---
 rtl/encoder83_pkg.sv | 13 +
 rtl/encoder83_queue_if.sv | 25 ++
 rtl/pri_pick8.sv | 34 +++
 rtl/encoder83_queue.sv | 95 +++++++++
 tb/tb_encoder83_queue.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/encoder83_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder.
// Holds the FSM state encoding and the request/code widths.
package encoder83_pkg;

    localparam int REQ_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/encoder83_queue_if.sv
// Handshake bundle between a request producer, the encoder and a code consumer.
// slave: encoder side; master: producer/consumer (testbench) side.
interface encoder83_queue_if;
    import encoder83_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REQ_W-1:0]  in_req;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] out_code;
    logic              out_last;
    logic              zero_err;

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_code, out_last, zero_err
    );

    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_code, out_last, zero_err
    );

endinterface

// File: rtl/pri_pick8.sv
// Combinational priority picker over an 8-bit vector.
// Ports: vec_i (bitmap), idx_o (chosen index), one_hot_o (exactly one bit set).
module pri_pick8
    import encoder83_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [REQ_W-1:0]  vec_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              one_hot_o
);

    // The last match written in the loop wins, so scan away from the
    // preferred end.
    always_comb begin
        idx_o = '0;
        if (LSB_FIRST) begin
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (vec_i[i]) idx_o = CODE_W'(i);
            end
        end else begin
            for (int i = 0; i < REQ_W; i++) begin
                if (vec_i[i]) idx_o = CODE_W'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit; zero afterwards means one bit.
    always_comb begin
        one_hot_o = (vec_i != '0) &&
                    ((vec_i & (vec_i - REQ_W'(1))) == '0);
    end

endmodule

// File: rtl/encoder83_queue.sv
// Sequential 8-to-3 encoder: emits the index of every set request bit, one per handshake.
// Ports: sys_clk, sys_rst (sync, active-high), bus (encoder83_queue_if.slave).
module encoder83_queue
    import encoder83_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    encoder83_queue_if.slave   bus
);

    state_t            state_q;
    logic [REQ_W-1:0]  pending_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [CODE_W-1:0] code_q;
    logic              last_q;
    logic              zerr_q;

    logic [REQ_W-1:0]  served_d;
    logic [REQ_W-1:0]  pick_in_d;
    logic [CODE_W-1:0] pick_idx_d;
    logic              pick_one_d;

    // Remaining bits once the code on the bus has been consumed.
    always_comb begin
        served_d = pending_q & ~(REQ_W'(1) << code_q);
    end

    // One picker serves both the fresh word and the leftover bits.
    always_comb begin
        pick_in_d = (state_q == IDLE) ? bus.in_req : served_d;
    end

    pri_pick8 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_pick (
        .vec_i     (pick_in_d),
        .idx_o     (pick_idx_d),
        .one_hot_o (pick_one_d)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            last_q      <= 1'b0;
            zerr_q      <= 1'b0;
        end else begin
            zerr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_req != '0) begin
                            pending_q   <= bus.in_req;
                            code_q      <= pick_idx_d;
                            last_q      <= pick_one_d;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= SCAN;
                        end else begin
                            zerr_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        pending_q <= served_d;
                        if (last_q) begin
                            last_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            code_q <= pick_idx_d;
                            last_q <= pick_one_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = code_q;
    assign bus.out_last  = last_q;
    assign bus.zero_err  = zerr_q;

endmodule

// File: tb/tb_encoder83_queue.sv
// Scoreboard bench for encoder83_queue, LSB-first and MSB-first instances in lockstep.
// Expected codes are queued when a word is driven and popped on each output handshake.
module tb_encoder83_queue;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_req;
    logic       out_ready;

    int checks = 0;
    int fails  = 0;

    logic [3:0] q1[$];
    logic [3:0] q0[$];
    logic [3:0] e1;
    logic [3:0] e0;

    encoder83_queue_if b1 ();
    encoder83_queue_if b0 ();

    assign b1.in_valid  = in_valid;
    assign b1.in_req    = in_req;
    assign b1.out_ready = out_ready;
    assign b0.in_valid  = in_valid;
    assign b0.in_req    = in_req;
    assign b0.out_ready = out_ready;

    encoder83_queue #(.LSB_FIRST(1'b1)) dut1 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (b1)
    );

    encoder83_queue #(.LSB_FIRST(1'b0)) dut0 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] w);
        int cnt;
        int seen;
        cnt  = $countones(w);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) begin
                seen++;
                q1.push_back({3'(i), seen == cnt});
            end
        end
        seen = 0;
        for (int i = 7; i >= 0; i--) begin
            if (w[i]) begin
                seen++;
                q0.push_back({3'(i), seen == cnt});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("excl1", 32'(b1.in_ready & b1.out_valid), 0);
            chk("excl0", 32'(b0.in_ready & b0.out_valid), 0);
            if (b1.out_valid && b1.out_ready) begin
                chk("sb1_nonempty", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("code1", 32'(b1.out_code), 32'(e1[3:1]));
                    chk("last1", 32'(b1.out_last), 32'(e1[0]));
                end
            end
            if (b0.out_valid && b0.out_ready) begin
                chk("sb0_nonempty", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    chk("code0", 32'(b0.out_code), 32'(e0[3:1]));
                    chk("last0", 32'(b0.out_last), 32'(e0[0]));
                end
            end
        end
    end

    // Waits for in_ready, presents one word for one edge, then
    // optionally counts output beats (requires out_ready held high).
    task automatic send(input logic [7:0] w, input bit count);
        int  n;
        bit  ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (b1.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rdy_wait", 32'(ok), 1);
        in_valid = 1'b1;
        in_req   = w;
        push_exp(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (w == 8'h00) begin
            @(negedge clk);
            chk("zerr_hi", 32'(b1.zero_err), 1);
            chk("zerr_ov", 32'(b1.out_valid), 0);
            chk("zerr_rdy", 32'(b1.in_ready), 1);
            @(negedge clk);
            chk("zerr_lo", 32'(b1.zero_err), 0);
            chk("zerr_ov2", 32'(b1.out_valid), 0);
        end else if (count) begin
            n = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!b1.out_valid) break;
                n++;
            end
            chk("beats", n, $countones(w));
            chk("idle_rdy", 32'(b1.in_ready), 1);
        end
    endtask

    task automatic drain(input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom);
            @(negedge clk);
            if (q1.size() == 0 && q0.size() == 0 && b1.in_ready) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", 32'(done), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_req    = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(b1.in_ready), 1);
        chk("rst_ov", 32'(b1.out_valid), 0);
        chk("rst_code", 32'(b1.out_code), 0);
        chk("rst_last", 32'(b1.out_last), 0);
        chk("rst_zerr", 32'(b1.zero_err), 0);

        out_ready = 1'b1;
        send(8'h01, 1'b1);
        send(8'h81, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);

        // Backpressure with a second word offered during SCAN.
        out_ready = 1'b0;
        send(8'h24, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid = 1'b1;
                in_req   = 8'h0F;
            end
            chk("bp_code1", 32'(b1.out_code), 2);
            chk("bp_code0", 32'(b0.out_code), 5);
            chk("bp_last", 32'(b1.out_last), 0);
            chk("bp_ov", 32'(b1.out_valid), 1);
            chk("bp_pend", 32'(dut1.pending_q), 32'h24);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bp_noecho", 32'(b1.out_valid), 0);
        end

        // Reset after the second handshake of a four-bit word.
        send(8'hF0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (q1.size() <= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_wait", 32'(ok), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q1.delete();
        q0.delete();
        @(negedge clk);
        chk("mrst_ov", 32'(b1.out_valid), 0);
        chk("mrst_rdy", 32'(b1.in_ready), 1);
        chk("mrst_code", 32'(b1.out_code), 0);
        chk("mrst_pend1", 32'(dut1.pending_q), 0);
        chk("mrst_pend0", 32'(dut0.pending_q), 0);

        for (int k = 0; k < 12; k++) begin
            send(8'($urandom_range(1, 255)), 1'b0);
            drain(1'b1);
        end
        send(8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
